mac_array_ctrl: RTL and testbench

- Sequencer for one row of weight-stationary mac tiles.
- Streams kernel words, then activation vectors, from a 1-cycle-latency SRAM into the west edge of the row, and drives the 2-bit tile instruction (inst[1] execute, inst[0] kernel load).
- Tracks in-flight vectors with a valid delay line and pulses the output-FIFO write when each psum emerges.
- Start/done handshake toward the top-level core; stalls on output-FIFO full.

---
 rtl/mac_pkg.sv | 26 ++
 rtl/valid_delay_line.sv | 34 +++
 rtl/mac_array_ctrl.sv | 109 ++++++++++
 tb/tb_mac_array_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared encodings and defaults for the mac tile row and its sequencer.
package mac_pkg;

  localparam logic [1:0] INST_IDLE  = 2'b00;
  localparam logic [1:0] INST_KLOAD = 2'b01;
  localparam logic [1:0] INST_EXEC  = 2'b10;

  localparam int COL_DEF      = 8;
  localparam int PIPE_LAT_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_KLOAD = 3'd1,
    ST_EXEC  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // One counter serves both the kernel-word and the vector phases.
  function automatic int cnt_width(input int col, input int len_w);
    int kw;
    kw = $clog2(col) + 1;
    return (len_w > kw) ? len_w : kw;
  endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth valid shift register: tail_vld is shift_vld delayed by depth cycles, no stall.
// any_vld is set when a valid will still be inside the line after the coming edge.
module valid_delay_line #(
  parameter int depth = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic shift_vld,
  output logic tail_vld,
  output logic any_vld
);

  logic [depth-1:0] sr;

  generate
    if (depth == 1) begin : g_one
      always_ff @(posedge clk) begin
        if (!reset) sr <= '0;
        else        sr <= shift_vld;
      end
      assign any_vld = shift_vld;
    end else begin : g_many
      always_ff @(posedge clk) begin
        if (!reset) sr <= '0;
        else        sr <= {sr[depth-2:0], shift_vld};
      end
      // The entry leaving this cycle does not count as still pending.
      assign any_vld = shift_vld | (|sr[depth-2:0]);
    end
  endgenerate

  assign tail_vld = sr[depth-1];

endmodule

// File: rtl/mac_array_ctrl.sv
// Row sequencer: kernel load then activation stream; first ofifo_wr 1+col+1+pipe_lat cycles after start.
// ofifo_full only gates activation reads (bubbles); kernel load and drain ignore it.
module mac_array_ctrl
  import mac_pkg::*;
#(
  parameter int col      = COL_DEF,
  parameter int addr_w   = 11,
  parameter int len_w    = 8,
  parameter int w_base   = 0,
  parameter int a_base   = 64,
  parameter int pipe_lat = PIPE_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              skip_kload,
  input  logic [len_w-1:0]  len,
  input  logic              ofifo_full,
  output logic              mem_rd,
  output logic [addr_w-1:0] mem_addr,
  output logic [1:0]        inst_w,
  output logic              ofifo_wr,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = cnt_width(col, len_w);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [len_w-1:0]   len_q;
  logic               kload_last, exec_last;
  logic               any_vld;

  assign kload_last = (cnt == CNT_W'(col - 1));
  assign exec_last  = (cnt == CNT_W'(len_q) - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (!skip_kload)   state_nxt = ST_KLOAD;
          else if (len != 0) state_nxt = ST_EXEC;
          // Empty reuse job passes through FLUSH so busy is seen for one cycle.
          else               state_nxt = ST_FLUSH;
        end
      end
      ST_KLOAD: begin
        mem_rd = 1'b1;
        if (kload_last) state_nxt = (len_q != 0) ? ST_EXEC : ST_FLUSH;
      end
      ST_EXEC: begin
        mem_rd = !ofifo_full;
        if (mem_rd && exec_last) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (inst_w == INST_IDLE && !any_vld) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt   <= '0;
      len_q <= '0;
    end else begin
      if (state == ST_IDLE && start) len_q <= len;
      if (state != state_nxt) cnt <= '0;
      else if (mem_rd)        cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    mem_addr = '0;
    case (state)
      ST_KLOAD: mem_addr = addr_w'(w_base) + addr_w'(cnt);
      ST_EXEC:  mem_addr = addr_w'(a_base) + addr_w'(cnt);
      default:  mem_addr = '0;
    endcase
  end

  // Instruction lags the read by one cycle to line up with SRAM data.
  always_ff @(posedge clk) begin
    if (!reset)      inst_w <= INST_IDLE;
    else if (mem_rd) inst_w <= (state == ST_KLOAD) ? INST_KLOAD : INST_EXEC;
    else             inst_w <= INST_IDLE;
  end

  valid_delay_line #(.depth(pipe_lat)) u_vdl (
    .clk       (clk),
    .reset     (reset),
    .shift_vld (inst_w == INST_EXEC),
    .tail_vld  (ofifo_wr),
    .any_vld   (any_vld)
  );

  assign busy = (state == ST_KLOAD) || (state == ST_EXEC) || (state == ST_FLUSH);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Randomized bench for mac_array_ctrl against a per-job cycle timeline model.
module tb_mac_array_ctrl;

  localparam int COL    = 8;
  localparam int PIPE   = 16;
  localparam int W_BASE = 0;
  localparam int A_BASE = 64;
  localparam int AMOD   = 2048;
  localparam int MAXC   = 256;

  logic        clk;
  logic        reset;
  logic        start;
  logic        skip_kload;
  logic [7:0]  len;
  logic        ofifo_full;
  logic        mem_rd;
  logic [10:0] mem_addr;
  logic [1:0]  inst_w;
  logic        ofifo_wr;
  logic        busy;
  logic        done;

  mac_array_ctrl #(
    .col(COL), .addr_w(11), .len_w(8), .w_base(W_BASE), .a_base(A_BASE), .pipe_lat(PIPE)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .skip_kload(skip_kload), .len(len),
    .ofifo_full(ofifo_full), .mem_rd(mem_rd), .mem_addr(mem_addr), .inst_w(inst_w),
    .ofifo_wr(ofifo_wr), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int job_id   = 0;

  bit fullv  [MAXC];
  int e_rd   [MAXC];
  int e_addr [MAXC];
  bit e_achk [MAXC];
  int e_inst [MAXC];
  int e_wr   [MAXC];
  int e_busy [MAXC];
  int e_done [MAXC];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_full();
    for (int i = 0; i < MAXC; i++) fullv[i] = 1'b0;
  endtask

  task automatic random_full();
    for (int i = 0; i < MAXC; i++) fullv[i] = (i < 150) && ($urandom_range(0, 3) == 0);
  endtask

  // Timeline: kernel words at cycles 1..COL, then one activation read per
  // non-full cycle; each read yields its instruction one cycle later and each
  // exec instruction yields a write PIPE cycles after that.
  task automatic build_model(input bit skip, input int ln, output int dc);
    int c, last_inst, last_wr;
    for (int i = 0; i < MAXC; i++) begin
      e_rd[i] = 0; e_addr[i] = 0; e_achk[i] = 1'b0; e_inst[i] = 0;
      e_wr[i] = 0; e_busy[i] = 0; e_done[i] = 0;
    end
    c = 1; last_inst = -1; last_wr = -1;
    if (!skip) begin
      for (int i = 0; i < COL; i++) begin
        e_rd[c] = 1; e_addr[c] = (W_BASE + i) % AMOD; e_achk[c] = 1'b1;
        e_inst[c+1] = 1; last_inst = c + 1;
        c++;
      end
    end
    for (int k = 0; k < ln; k++) begin
      while (fullv[c]) begin
        e_addr[c] = (A_BASE + k) % AMOD; e_achk[c] = 1'b1;
        c++;
      end
      e_rd[c] = 1; e_addr[c] = (A_BASE + k) % AMOD; e_achk[c] = 1'b1;
      e_inst[c+1] = 2; e_wr[c+1+PIPE] = 1;
      last_inst = c + 1; last_wr = c + 1 + PIPE;
      c++;
    end
    if (last_inst < 0) dc = 2;
    else dc = (last_inst + 2 > last_wr + 1) ? last_inst + 2 : last_wr + 1;
    for (int i = 1; i < dc; i++) e_busy[i] = 1;
    e_done[dc] = 1;
  endtask

  task automatic run_job(input bit skip, input int ln, input bit spur,
                         output int first_wr, output int done_obs);
    int dc;
    build_model(skip, ln, dc);
    first_wr = -1; done_obs = -1;
    for (int n = 0; n <= dc + 1; n++) begin
      @(posedge clk); #1;
      start      = (n == 0) || (spur && n >= 1 && n <= dc &&
                   (n == 1 || n == dc || $urandom_range(0, 3) == 0));
      skip_kload = (n == 0) ? skip : 1'($urandom_range(0, 1));
      len        = (n == 0) ? 8'(ln) : 8'($urandom_range(0, 255));
      ofifo_full = fullv[n];
      #1;
      check_eq($sformatf("j%0d c%0d mem_rd", job_id, n), int'(mem_rd), e_rd[n]);
      check_eq($sformatf("j%0d c%0d inst_w", job_id, n), int'(inst_w), e_inst[n]);
      check_eq($sformatf("j%0d c%0d ofifo_wr", job_id, n), int'(ofifo_wr), e_wr[n]);
      check_eq($sformatf("j%0d c%0d busy", job_id, n), int'(busy), e_busy[n]);
      check_eq($sformatf("j%0d c%0d done", job_id, n), int'(done), e_done[n]);
      if (e_achk[n])
        check_eq($sformatf("j%0d c%0d mem_addr", job_id, n), int'(mem_addr), e_addr[n]);
      if (ofifo_wr && first_wr < 0) first_wr = n;
      if (done && done_obs < 0) done_obs = n;
    end
    start = 1'b0;
    job_id++;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, " mem_rd"},   int'(mem_rd),   0);
    check_eq({tag, " inst_w"},   int'(inst_w),   0);
    check_eq({tag, " ofifo_wr"}, int'(ofifo_wr), 0);
    check_eq({tag, " busy"},     int'(busy),     0);
    check_eq({tag, " done"},     int'(done),     0);
  endtask

  initial begin
    int fw, dn;
    reset = 1'b0; start = 1'b0; skip_kload = 1'b0; len = '0; ofifo_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    check_eq("reset mem_addr", int'(mem_addr), 0);
    reset = 1'b1;

    clear_full();
    run_job(1'b0, 4, 1'b0, fw, dn);
    check_eq("basic first_wr", fw, 26);
    check_eq("basic done", dn, 30);

    clear_full();
    fullv[10] = 1'b1; fullv[11] = 1'b1; fullv[12] = 1'b1;
    run_job(1'b0, 4, 1'b0, fw, dn);
    check_eq("stall first_wr", fw, 26);
    check_eq("stall done", dn, 33);

    clear_full();
    run_job(1'b1, 0, 1'b0, fw, dn);
    check_eq("skip0 done", dn, 2);

    run_job(1'b0, 0, 1'b0, fw, dn);
    check_eq("kload0 first_wr", fw, -1);
    check_eq("kload0 done", dn, 11);

    run_job(1'b1, 3, 1'b1, fw, dn);
    check_eq("spur done", dn, 21);

    // Abort a job during its third activation read.
    for (int n = 0; n <= 40; n++) begin
      @(posedge clk); #1;
      start = (n == 0); skip_kload = 1'b0; len = 8'd6; ofifo_full = 1'b0;
      reset = (n == 11) ? 1'b0 : 1'b1;
      #1;
      if (n == 11) begin
        check_eq("abort pre mem_rd", int'(mem_rd), 1);
        check_eq("abort pre mem_addr", int'(mem_addr), 66);
        check_eq("abort pre inst_w", int'(inst_w), 2);
      end
      if (n >= 12) check_idle_outputs($sformatf("abort c%0d", n));
    end
    start = 1'b0;

    random_full();
    run_job(1'b0, $urandom_range(1, 24), 1'b1, fw, dn);

    for (int j = 0; j < 12; j++) begin
      random_full();
      run_job(1'($urandom_range(0, 1)), $urandom_range(0, 24), 1'($urandom_range(0, 1)), fw, dn);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
